// File: rtl/prach_hb1_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : prach_hb1_sched_if
// Description : TDM sample stream into, and polyphase pair stream out of, the
//               halfband-1 front-end sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface prach_hb1_sched_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] din_dq;
    logic             din_dv;
    logic [7:0]       din_chn;
    logic             sync_in;

    logic [WIDTH-1:0] dout_dp1;
    logic [WIDTH-1:0] dout_dp2;
    logic             dout_dv;
    logic [7:0]       dout_chn;
    logic             sync_out;

    modport master (
        output din_dq, din_dv, din_chn, sync_in,
        input  dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out
    );

    modport slave (
        input  din_dq, din_dv, din_chn, sync_in,
        output dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out
    );
endinterface
`default_nettype wire

// File: rtl/prach_hb1_sched.sv
`default_nettype none
// ============================================================================
// Module      : prach_hb1_sched
// Description : Front-end sequencer for the TDM halfband-1 decimator. Pairs
//               even/odd input frames and issues one output frame per pair.
// Revision    : 1.0 - initial release
// ============================================================================
module prach_hb1_sched #(
    parameter int NUM_CHANNEL = 16,
    parameter int WIDTH       = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           en,
    prach_hb1_sched_if.slave    bus,
    output logic                err_seq,
    output logic                err_sync,
    output logic [15:0]         frame_cnt
);

    localparam int         c_IDX_W    = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
    localparam logic [7:0] c_LAST_CHN = 8'(NUM_CHANNEL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVEN = 2'd1,
        S_ODD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_exp_chn;
    logic [7:0]         w_exp_nxt;
    logic [7:0]         w_exp_inc;
    logic               w_wr;
    logic               w_emit;
    logic               w_seq_err;
    logic               w_sync_err;
    logic               w_sync_ok;
    logic               w_chn_ok;
    logic [c_IDX_W-1:0] w_idx;

    logic [WIDTH-1:0]   r_buf [NUM_CHANNEL];

    logic [WIDTH-1:0]   r_dp1;
    logic [WIDTH-1:0]   r_dp2;
    logic               r_dv;
    logic [7:0]         r_chn;
    logic               r_sync;
    logic               r_err_seq;
    logic               r_err_sync;
    logic [15:0]        r_frame_cnt;

    assign w_idx     = bus.din_chn[c_IDX_W-1:0];
    assign w_sync_ok = bus.din_dv & bus.sync_in & (bus.din_chn == 8'd0);
    assign w_chn_ok  = (bus.din_chn == r_exp_chn);
    assign w_exp_inc = (r_exp_chn == c_LAST_CHN) ? 8'd0 : r_exp_chn + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_exp_chn;
        w_wr        = 1'b0;
        w_emit      = 1'b0;
        w_seq_err   = 1'b0;
        w_sync_err  = 1'b0;

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_exp_nxt   = 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sync_ok) begin
                        w_state_nxt = S_EVEN;
                        w_exp_nxt   = 8'd1;
                        w_wr        = 1'b1;
                    end
                end
                S_EVEN, S_ODD: begin
                    if (bus.din_dv) begin
                        if (!w_chn_ok) begin
                            w_seq_err = 1'b1;
                            // A misordered sample that is itself a valid sync realigns at once
                            if (w_sync_ok) begin
                                w_state_nxt = S_EVEN;
                                w_exp_nxt   = 8'd1;
                                w_wr        = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                                w_exp_nxt   = 8'd0;
                            end
                        end else if ((r_state == S_ODD) && w_sync_ok) begin
                            // Sync at the start of an odd frame: abandon it, restart as even
                            w_sync_err  = 1'b1;
                            w_state_nxt = S_EVEN;
                            w_exp_nxt   = 8'd1;
                            w_wr        = 1'b1;
                        end else begin
                            w_exp_nxt = w_exp_inc;
                            if (r_state == S_EVEN) begin
                                w_wr = 1'b1;
                            end else begin
                                w_emit = 1'b1;
                            end
                            if (r_exp_chn == c_LAST_CHN) begin
                                w_state_nxt = (r_state == S_EVEN) ? S_ODD : S_EVEN;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_exp_nxt   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_exp_chn   <= 8'd0;
            r_dp1       <= '0;
            r_dp2       <= '0;
            r_dv        <= 1'b0;
            r_chn       <= 8'd0;
            r_sync      <= 1'b0;
            r_err_seq   <= 1'b0;
            r_err_sync  <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_exp_chn  <= w_exp_nxt;
            r_dv       <= w_emit;
            r_sync     <= w_emit & (bus.din_chn == 8'd0);
            r_err_seq  <= w_seq_err;
            r_err_sync <= w_sync_err;
            if (w_emit) begin
                r_dp1 <= r_buf[w_idx];
                r_dp2 <= bus.din_dq;
                r_chn <= bus.din_chn;
            end
            if (w_emit && (bus.din_chn == 8'd0)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Even write and odd read of one channel are a full frame apart, so no bypass
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[w_idx] <= bus.din_dq;
        end
    end

    assign bus.dout_dp1 = r_dp1;
    assign bus.dout_dp2 = r_dp2;
    assign bus.dout_dv  = r_dv;
    assign bus.dout_chn = r_chn;
    assign bus.sync_out = r_sync;
    assign err_seq      = r_err_seq;
    assign err_sync     = r_err_sync;
    assign frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prach_hb1_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_prach_hb1_sched
// Description : Directed self-checking bench for prach_hb1_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prach_hb1_sched;

    localparam int NCH = 16;
    localparam int W   = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        err_seq;
    logic        err_sync;
    logic [15:0] frame_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_dp1 = 16'd0;
    logic [15:0] last_dp2 = 16'd0;

    prach_hb1_sched_if #(.WIDTH(W)) bus ();

    prach_hb1_sched #(
        .NUM_CHANNEL (NCH),
        .WIDTH       (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .err_seq   (err_seq),
        .err_sync  (err_sync),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One input cycle; the output seen 1 clk later belongs to this sample
    task automatic cyc(input bit dv, input int chn, input int dq, input bit sy,
                       input bit edv, input int e1, input bit eseq, input bit esyn,
                       input string tag);
        @(negedge clk);
        bus.din_dv  = dv;
        bus.din_chn = 8'(chn);
        bus.din_dq  = 16'(dq);
        bus.sync_in = sy;
        @(posedge clk);
        #1;
        chk({tag, ".dv"},       32'(bus.dout_dv),  32'(edv));
        chk({tag, ".sync_out"}, 32'(bus.sync_out), 32'(edv && (chn == 0)));
        chk({tag, ".err_seq"},  32'(err_seq),      32'(eseq));
        chk({tag, ".err_sync"}, 32'(err_sync),     32'(esyn));
        if (edv) begin
            chk({tag, ".dp1"}, 32'(bus.dout_dp1), 32'(16'(e1)));
            chk({tag, ".dp2"}, 32'(bus.dout_dp2), 32'(16'(dq)));
            chk({tag, ".chn"}, 32'(bus.dout_chn), 32'(8'(chn)));
            last_dp1 = 16'(e1);
            last_dp2 = 16'(dq);
        end else begin
            chk({tag, ".dp1_hold"}, 32'(bus.dout_dp1), 32'(last_dp1));
            chk({tag, ".dp2_hold"}, 32'(bus.dout_dp2), 32'(last_dp2));
        end
    endtask

    // Full frame: dq = base+k; when emit, dp1 = pbase+k; gap adds a dv=0 cycle every 3rd cycle
    task automatic frame(input int base, input bit sy, input bit emit, input int pbase,
                         input bit gap, input string tag);
        for (int k = 0; k < NCH; k++) begin
            cyc(1'b1, k, base + k, sy && (k == 0), emit, pbase + k, 1'b0, 1'b0, tag);
            if (gap && (k % 2 == 1)) begin
                cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, {tag, ".gap"});
            end
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n       = 1'b0;
        bus.din_dv  = 1'b1;
        bus.din_chn = 8'd4;
        bus.din_dq  = 16'h55AA;
        bus.sync_in = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, ".dv"},       32'(bus.dout_dv),  32'd0);
        chk({tag, ".dp1"},      32'(bus.dout_dp1), 32'd0);
        chk({tag, ".dp2"},      32'(bus.dout_dp2), 32'd0);
        chk({tag, ".chn"},      32'(bus.dout_chn), 32'd0);
        chk({tag, ".sync_out"}, 32'(bus.sync_out), 32'd0);
        chk({tag, ".err_seq"},  32'(err_seq),      32'd0);
        chk({tag, ".err_sync"}, 32'(err_sync),     32'd0);
        chk({tag, ".frame_cnt"}, 32'(frame_cnt),   32'd0);
        last_dp1 = 16'd0;
        last_dp2 = 16'd0;
        @(negedge clk);
        rst_n      = 1'b1;
        bus.din_dv = 1'b0;
    endtask

    initial begin
        bus.din_dv  = 1'b0;
        bus.din_chn = 8'd0;
        bus.din_dq  = 16'd0;
        bus.sync_in = 1'b0;

        do_reset("rst0");
        en = 1'b1;

        // Continuous ramp, 4 frames
        frame(0,  1'b1, 1'b0, 0,  1'b0, "s1.f0");
        frame(16, 1'b0, 1'b1, 0,  1'b0, "s1.f1");
        frame(32, 1'b1, 1'b0, 0,  1'b0, "s1.f2");
        frame(48, 1'b0, 1'b1, 32, 1'b0, "s1.f3");
        chk("s1.frame_cnt", 32'(frame_cnt), 32'd2);

        // Same ramp with a gap every 3rd cycle
        frame(0,  1'b1, 1'b0, 0,  1'b1, "s2.f0");
        frame(16, 1'b0, 1'b1, 0,  1'b1, "s2.f1");
        frame(32, 1'b1, 1'b0, 0,  1'b1, "s2.f2");
        frame(48, 1'b0, 1'b1, 32, 1'b1, "s2.f3");
        chk("s2.frame_cnt", 32'(frame_cnt), 32'd4);

        // Drop to IDLE, then samples before sync are ignored
        en = 1'b0;
        cyc(1'b1, 0, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, "s3.en0");
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, k, 900 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s3.presync");
        end
        frame(1000, 1'b1, 1'b0, 0,    1'b0, "s3.f0");
        frame(2000, 1'b0, 1'b1, 1000, 1'b0, "s3.f1");
        chk("s3.frame_cnt", 32'(frame_cnt), 32'd5);

        // Channel-order error in an even frame: 0..6 then 8
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, k, 256 + k, k == 0, 1'b0, 0, 1'b0, 1'b0, "s4.even");
        end
        cyc(1'b1, 8, 264, 1'b0, 1'b0, 0, 1'b1, 1'b0, "s4.bad");
        for (int k = 9; k < NCH; k++) begin
            cyc(1'b1, k, 256 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s4.idle");
        end
        frame(3000, 1'b1, 1'b0, 0,    1'b0, "s4.f0");
        frame(4000, 1'b0, 1'b1, 3000, 1'b0, "s4.f1");
        chk("s4.frame_cnt", 32'(frame_cnt), 32'd6);

        // Sync arriving at chn0 of an odd frame
        frame(100, 1'b1, 1'b0, 0, 1'b0, "s5.f0");
        cyc(1'b1, 0, 200, 1'b1, 1'b0, 0, 1'b0, 1'b1, "s5.oddsync");
        for (int k = 1; k < NCH; k++) begin
            cyc(1'b1, k, 200 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s5.reeven");
        end
        frame(300, 1'b0, 1'b1, 200, 1'b0, "s5.f1");
        chk("s5.frame_cnt", 32'(frame_cnt), 32'd7);

        // en drop after chn5 of an odd frame
        frame(400, 1'b1, 1'b0, 0, 1'b0, "s6.f0");
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, k, 500 + k, 1'b0, 1'b1, 400 + k, 1'b0, 1'b0, "s6.odd");
        end
        en = 1'b0;
        for (int k = 6; k < 10; k++) begin
            cyc(1'b1, k, 500 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s6.off");
        end
        en = 1'b1;
        for (int k = 10; k < NCH; k++) begin
            cyc(1'b1, k, 500 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s6.nosync");
        end
        frame(600, 1'b1, 1'b0, 0,   1'b0, "s6.f2");
        frame(700, 1'b0, 1'b1, 600, 1'b0, "s6.f3");
        chk("s6.frame_cnt", 32'(frame_cnt), 32'd9);

        // Reset in the middle of an odd frame
        frame(800, 1'b1, 1'b0, 0, 1'b0, "s7.f0");
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, k, 900 + k, 1'b0, 1'b1, 800 + k, 1'b0, 1'b0, "s7.odd");
        end
        do_reset("s7.rst");
        for (int k = 4; k < 7; k++) begin
            cyc(1'b1, k, 900 + k, 1'b0, 1'b0, 0, 1'b0, 1'b0, "s7.post");
        end
        frame(1100, 1'b1, 1'b0, 0,    1'b0, "s7.f1");
        frame(1200, 1'b0, 1'b1, 1100, 1'b0, "s7.f2");
        chk("s7.frame_cnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
